// File: rtl/projectile_game_sm.sv
// projectile_game_sm
//   Game-control FSM feeding the vga_bitchange projectile renderer. It turns
//   button pulses into a launch velocity, strobes shoot/animate, watches the
//   rendered projectile position for a hit or miss, and holds each result for
//   RESULT_CYCLES clocks before returning to aiming.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   BtnL/BtnR, BtnD/BtnU       single-cycle pulses: vX -/+ , vY -/+
//   BtnC                       single-cycle fire pulse
//   projectileCenterX/Y [9:0]  projectile position from the renderer
//   t_air [49:0]               flight tick count from the renderer
//   vX, vY [3:0]               saturating launch velocity
//   X_INITIAL, Y_INITIAL [9:0] constant launch coordinates
//   q_Init..q_Miss             registered one-hot state outputs
//   hits, shots [7:0]          score counters
//
// Build option
//   SCORE_COUNT_EN  when defined, hits/shots are saturating counters;
//                   otherwise they are tied to zero.
module projectile_game_sm #(
  parameter logic [9:0]  X_LAUNCH      = 10'd215,
  parameter logic [9:0]  Y_LAUNCH      = 10'd465,
  parameter logic [3:0]  VX_RESET      = 4'd4,
  parameter logic [3:0]  VY_RESET      = 4'd8,
  parameter int unsigned MAX_TAIR      = 40,
  parameter int unsigned RESULT_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        BtnL,
  input  logic        BtnR,
  input  logic        BtnD,
  input  logic        BtnU,
  input  logic        BtnC,
  input  logic [9:0]  projectileCenterX,
  input  logic [9:0]  projectileCenterY,
  input  logic [49:0] t_air,
  output logic [3:0]  vX,
  output logic [3:0]  vY,
  output logic [9:0]  X_INITIAL,
  output logic [9:0]  Y_INITIAL,
  output logic        q_Init,
  output logic        q_Aim,
  output logic        q_P1Shoot,
  output logic        q_Animate,
  output logic        q_Hit,
  output logic        q_Miss,
  output logic [7:0]  hits,
  output logic [7:0]  shots
);

  localparam logic [2:0] INIT    = 3'd0;
  localparam logic [2:0] AIM     = 3'd1;
  localparam logic [2:0] P1SHOOT = 3'd2;
  localparam logic [2:0] ANIMATE = 3'd3;
  localparam logic [2:0] HIT     = 3'd4;
  localparam logic [2:0] MISS    = 3'd5;

  localparam logic [26:0] HOLD_LAST  = 27'(RESULT_CYCLES - 1);
  localparam logic [49:0] TAIR_LIMIT = 50'(MAX_TAIR);

  logic [2:0]  state, next_state;
  logic [26:0] hold_cnt;
  logic [10:0] x_ext, y_ext;
  logic        hit_det, miss_det;

  assign X_INITIAL = X_LAUNCH;
  assign Y_INITIAL = Y_LAUNCH;

  // 11-bit zero-extended so the +5/+2 box margins cannot wrap.
  assign x_ext = {1'b0, projectileCenterX};
  assign y_ext = {1'b0, projectileCenterY};

  assign hit_det = (x_ext + 11'd5 >= 11'd650) && (x_ext <= 11'd675) &&
                   (y_ext + 11'd2 >= 11'd470) && (y_ext <= 11'd475);

  // Y above 600 is a wrap past the top of the screen, not a ground miss.
  assign miss_det = ((y_ext >= 11'd473) && (y_ext <= 11'd600)) ||
                    (x_ext >= 11'd770) || (t_air >= TAIR_LIMIT);

  always_comb begin
    next_state = state;
    case (state)
      INIT:    next_state = AIM;
      AIM:     if (BtnC) next_state = P1SHOOT;
      P1SHOOT: next_state = ANIMATE;
      ANIMATE: begin
        if (hit_det)       next_state = HIT;
        else if (miss_det) next_state = MISS;
      end
      HIT, MISS: if (hold_cnt == HOLD_LAST) next_state = AIM;
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      q_Init    <= 1'b1;
      q_Aim     <= 1'b0;
      q_P1Shoot <= 1'b0;
      q_Animate <= 1'b0;
      q_Hit     <= 1'b0;
      q_Miss    <= 1'b0;
    end else begin
      state     <= next_state;
      q_Init    <= (next_state == INIT);
      q_Aim     <= (next_state == AIM);
      q_P1Shoot <= (next_state == P1SHOOT);
      q_Animate <= (next_state == ANIMATE);
      q_Hit     <= (next_state == HIT);
      q_Miss    <= (next_state == MISS);
    end
  end

  // Only ANIMATE precedes HIT/MISS, and the counter is held at zero outside
  // the result states, so it is already zero on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       hold_cnt <= '0;
    else if (state == HIT || state == MISS) hold_cnt <= hold_cnt + 27'd1;
    else                                hold_cnt <= '0;
  end

  // Velocity is only adjustable in AIM without a fire pulse; elsewhere frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vX <= VX_RESET;
      vY <= VY_RESET;
    end else if (state == AIM && !BtnC) begin
      if (BtnR && !BtnL && vX != 4'd15)      vX <= vX + 4'd1;
      else if (BtnL && !BtnR && vX != 4'd0)  vX <= vX - 4'd1;
      if (BtnU && !BtnD && vY != 4'd15)      vY <= vY + 4'd1;
      else if (BtnD && !BtnU && vY != 4'd0)  vY <= vY - 4'd1;
    end
  end

`ifdef SCORE_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hits  <= '0;
      shots <= '0;
    end else begin
      if (state == AIM && BtnC && shots != 8'hFF)        shots <= shots + 8'd1;
      if (state == ANIMATE && hit_det && hits != 8'hFF)  hits  <= hits + 8'd1;
    end
  end
`else
  assign hits  = '0;
  assign shots = '0;
`endif

endmodule
